disp_feeder: RTL and testbench
==============================

DISP_FEEDER -- requirements
Module: disp_feeder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH SHALL default to 27 and SHALL set the binary input width.
REQ-003 Parameter NDIG SHALL default to 8 and SHALL set the number of display digits written.
REQ-004 Port clock SHALL be an input, 1 bit: the single clock, rising-edge active.
REQ-005 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port value SHALL be an input, WIDTH bits: unsigned calculator result, sampled on start.
REQ-007 Port start SHALL be an input, 1 bit: single-cycle request to convert and display value.
REQ-008 Port busy SHALL be an output, 1 bit: conversion or write sequence in progress.
REQ-009 Port done SHALL be an output, 1 bit: one-cycle pulse when the sequence completes.
REQ-010 Port overflow SHALL be an output, 1 bit: the last accepted value exceeded 99_999_999.
REQ-011 Port dig SHALL be an output, 4 bits: BCD digit for the downstream display controller.
REQ-012 Port pos SHALL be an output, 4 bits: display index 0..7, or 15 (no write).

Function
REQ-013 The block SHALL feed the display controller, which writes dig into pos whenever pos<8 and dig<10; pos=15 SHALL therefore mean "no write".
REQ-014 The FSM SHALL have four states: IDLE, CONVERT, WRITE and FINISH.
REQ-015 IDLE: pos=15, dig=15, busy=0; a start sampled at edge k SHALL latch value, set overflow=(value>99_999_999) and enter CONVERT.
REQ-016 On overflow, the latched operand SHALL saturate to 99_999_999.
REQ-017 CONVERT SHALL run a double-dabble conversion, one shift per cycle, for exactly WIDTH (27) cycles: add 3 to each BCD nibble >=5, then shift left one bit.
REQ-018 WRITE SHALL last NDIG cycles; beat i (0..7) SHALL drive pos=i and dig=BCD nibble i, with nibble 0 as the least significant.
REQ-019 Timing for start sampled at edge k: busy=1 during cycles k+1..k+35; write beat i SHALL appear during cycle k+28+i; done=1 and busy=0 during cycle k+36 (FINISH); IDLE SHALL follow.
REQ-020 start SHALL be ignored while busy=1, and the in-flight sequence SHALL continue unchanged.
REQ-021 start SHALL be accepted in the FINISH cycle and SHALL begin a new sequence with no idle gap.
REQ-022 Outside WRITE, pos SHALL be 15, so the block never issues a spurious write.
REQ-023 overflow SHALL hold its value until the next accepted start.
REQ-024 All outputs SHALL be registered; no combinational path SHALL exist from inputs to outputs.
REQ-025 Leading zeros SHALL be written as digit 0; no blanking is applied.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, pos=15, dig=15, busy=0, done=0 and overflow=0, and SHALL clear the BCD and shift registers.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence; no further write beats SHALL be issued.
REQ-028 After reset deassertion, the first start SHALL behave per REQ-019.

Structure
REQ-029 Shared package calc_pkg SHALL hold NDIG, WIDTH, MAX_VAL=99_999_999, POS_IDLE=4'hF and the FSM state enum.
REQ-030 Sub-module dd_step SHALL implement one combinational double-dabble iteration (add-3 then shift) over NDIG nibbles plus the binary remainder.
REQ-031 The total RTL SHALL be 120-400 lines.

Verification
REQ-032 value=12_345_678 with start at cycle 0 -> cycles 28..35 show pos 0..7 with dig 8,7,6,5,4,3,2,1; done at cycle 36; overflow=0.
REQ-033 value=0 -> eight beats, all dig=0; value=99_999_999 -> all dig=9 with overflow=0.
REQ-034 value=100_000_000 -> overflow=1 and all eight beats dig=9.
REQ-035 value=5 accepted; start with value=7 at cycle 10 -> ignored; beats show 5,0,0,0,0,0,0,0.
REQ-036 reset pulled low at cycle 30 -> pos=15 and busy=0 immediately, no further beats; a later start with value=42 -> beats 2,4,0,0,0,0,0,0.
REQ-037 start asserted in the FINISH cycle with a new value -> a second sequence begins; its beat 0 appears exactly 28 cycles later.

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared constants and types for the calculator display feeder.
//   NDIG      number of BCD display digits written per result
//   WIDTH     width of the binary calculator result
//   MAX_VAL   largest value that fits in NDIG decimal digits
//   POS_IDLE  display index meaning "no write"
//   DIG_IDLE  digit driven whenever no write is in progress
//   state_t   feeder FSM states
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int NDIG    = 8;
    localparam int WIDTH   = 27;
    localparam int MAX_VAL = 99_999_999;

    localparam logic [3:0] POS_IDLE = 4'hF;
    localparam logic [3:0] DIG_IDLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

endpackage

// File: rtl/dd_step.sv
// ---------------------------------------------------------------------------
// dd_step
// One combinational double-dabble iteration: every BCD nibble that is >= 5
// gets 3 added, then the {bcd, bin} pair is shifted left by one bit so the
// MSB of the binary remainder enters BCD nibble 0.
// Ports:
//   bcd_i  [NDIG*4-1:0]  BCD accumulator before the step
//   bin_i  [WIDTH-1:0]   binary bits still to be shifted in
//   bcd_o  [NDIG*4-1:0]  BCD accumulator after the step
//   bin_o  [WIDTH-1:0]   binary remainder after the step
// ---------------------------------------------------------------------------
module dd_step #(
    parameter int NDIG  = calc_pkg::NDIG,
    parameter int WIDTH = calc_pkg::WIDTH
) (
    input  logic [NDIG*4-1:0] bcd_i,
    input  logic [WIDTH-1:0]  bin_i,
    output logic [NDIG*4-1:0] bcd_o,
    output logic [WIDTH-1:0]  bin_o
);

    logic [NDIG*4-1:0]       adj;
    logic [NDIG*4+WIDTH-1:0] shifted;

    always_comb begin
        adj = bcd_i;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_i[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_i[i*4 +: 4] + 4'd3;
            end
        end
    end

    // The top BCD bit falls off the end; it is always zero for in-range values.
    always_comb begin
        shifted = {adj, bin_i} << 1;
    end

    assign bcd_o = shifted[NDIG*4+WIDTH-1:WIDTH];
    assign bin_o = shifted[WIDTH-1:0];

endmodule

// File: rtl/disp_feeder.sv
// ---------------------------------------------------------------------------
// disp_feeder
// Converts an unsigned calculator result to BCD (one double-dabble step per
// cycle) and then presents the digits, least significant first, one per
// cycle to a display controller that writes dig into pos when pos < 8.
// Results above MAX_VAL are flagged and shown as all nines.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   value      [WIDTH-1:0] result, sampled when start is accepted
//   start      one-cycle request; accepted in IDLE and in FINISH only
//   busy       conversion or write sequence in progress
//   done       one-cycle pulse in the FINISH cycle
//   overflow   last accepted value exceeded MAX_VAL (held until next start)
//   dig        [3:0] BCD digit for the display controller (15 when idle)
//   pos        [3:0] display index 0..NDIG-1, or 15 for "no write"
//   dbg_state  current FSM state
// Timing for a start sampled at edge k: CONVERT during cycles k+1..k+WIDTH,
// WRITE beat i during cycle k+WIDTH+1+i, FINISH (done) right after.
// All outputs come straight from flops; their next values are computed
// together with the next state.
// ---------------------------------------------------------------------------
module disp_feeder #(
    parameter int WIDTH = calc_pkg::WIDTH,
    parameter int NDIG  = calc_pkg::NDIG
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       dig,
    output logic [3:0]       pos,
    output calc_pkg::state_t dbg_state
);

    import calc_pkg::*;

    localparam int              CW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [NDIG*4-1:0]  bcd_q, bcd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         beat_q, beat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [3:0]         dig_q, dig_d;
    logic [3:0]         pos_q, pos_d;

    logic [NDIG*4-1:0]  step_bcd;
    logic [WIDTH-1:0]   step_bin;
    logic [3:0]         next_beat;
    logic               val_ovf;

    dd_step #(
        .NDIG  (NDIG),
        .WIDTH (WIDTH)
    ) u_dd_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (step_bcd),
        .bin_o (step_bin)
    );

    assign next_beat = beat_q + 4'd1;
    assign val_ovf   = (value > MAX_W);

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pos_d   = POS_IDLE;
        dig_d   = DIG_IDLE;

        case (state_q)
            IDLE, FINISH: begin
                // FINISH accepts start too, so sequences can run back to back.
                if (start) begin
                    state_d = CONVERT;
                    ovf_d   = val_ovf;
                    bin_d   = val_ovf ? MAX_W : value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            CONVERT: begin
                busy_d = 1'b1;
                bin_d  = step_bin;
                bcd_d  = step_bcd;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last shift: the fresh BCD result feeds beat 0 directly.
                    state_d = WRITE;
                    beat_d  = 4'd0;
                    pos_d   = 4'd0;
                    dig_d   = step_bcd[3:0];
                end
            end

            WRITE: begin
                if (beat_q == 4'(NDIG - 1)) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    beat_d = next_beat;
                    pos_d  = next_beat;
                    dig_d  = bcd_q[next_beat*4 +: 4];
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dig_q   <= DIG_IDLE;
            pos_q   <= POS_IDLE;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
            pos_q   <= pos_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign dig       = dig_q;
    assign pos       = pos_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_disp_feeder.sv
module tb_disp_feeder;

    import calc_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [26:0] value = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  dig;
    logic [3:0]  pos;
    state_t      dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    disp_feeder dut (
        .clock     (clock),
        .reset     (reset),
        .value     (value),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .dig       (dig),
        .pos       (pos),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // checking
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " pos"},  32'(pos),  32'hF);
        chk({tag, " dig"},  32'(dig),  32'hF);
    endtask

    // drivers: called at a negedge, returns at the negedge of cycle k+1
    task automatic launch(input logic [26:0] v);
        value = v;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Follows one sequence cycle by cycle. ign: cycle whose edge sees a
    // stray start with value 7 (0 = none). chain: start next sequence from
    // the FINISH cycle. abort_at: cycle in which reset is pulled (0 = none).
    task automatic observe(input string name, input logic [31:0] exp_bcd,
                           input logic exp_ovf, input int ign, input bit chain,
                           input logic [26:0] nxt, input int abort_at);
        logic [31:0] e_busy, e_done, e_pos, e_dig;
        bit in_wr;
        bit aborted;
        aborted = 1'b0;
        for (int n = 1; n <= 36; n++) begin
            in_wr  = (n >= 28) && (n <= 35);
            e_busy = (n <= 35) ? 32'd1 : 32'd0;
            e_done = (n == 36) ? 32'd1 : 32'd0;
            e_pos  = in_wr ? 32'(n - 28) : 32'hF;
            e_dig  = in_wr ? 32'(exp_bcd[(n-28)*4 +: 4]) : 32'hF;
            chk($sformatf("%s busy c%0d", name, n), 32'(busy), e_busy);
            chk($sformatf("%s done c%0d", name, n), 32'(done), e_done);
            chk($sformatf("%s pos c%0d", name, n),  32'(pos),  e_pos);
            chk($sformatf("%s dig c%0d", name, n),  32'(dig),  e_dig);
            if (n == 1 || n == 36)
                chk($sformatf("%s ovf c%0d", name, n), 32'(overflow), 32'(exp_ovf));
            if (n == 1)  chk({name, " state convert"}, 32'(dbg_state), 32'(CONVERT));
            if (n == 28) chk({name, " state write"},   32'(dbg_state), 32'(WRITE));
            if (n == 36) chk({name, " state finish"},  32'(dbg_state), 32'(FINISH));
            if (n == abort_at) begin
                reset = 1'b0;
                #1;
                chk({name, " abort ovf"}, 32'(overflow), 32'd0);
                chk({name, " abort state"}, 32'(dbg_state), 32'(IDLE));
                chk_quiet({name, " abort now"});
                repeat (2) @(negedge clock);
                chk_quiet({name, " abort held"});
                reset = 1'b1;
                for (int j = 0; j < 12; j++) begin
                    @(negedge clock);
                    chk_quiet($sformatf("%s after abort c%0d", name, j));
                end
                aborted = 1'b1;
                break;
            end
            if (ign != 0 && n == ign - 1) begin
                value = 27'd7;
                start = 1'b1;
            end
            if (ign != 0 && n == ign) start = 1'b0;
            if (n == 36 && chain) begin
                value = nxt;
                start = 1'b1;
            end
            @(negedge clock);
        end
        if (!aborted) begin
            if (chain) begin
                start = 1'b0;
            end else begin
                chk_quiet({name, " idle"});
                chk({name, " idle ovf"},   32'(overflow),  32'(exp_ovf));
                chk({name, " idle state"}, 32'(dbg_state), 32'(IDLE));
            end
        end
    endtask

    // stimulus
    initial begin
        repeat (3) @(negedge clock);
        chk_quiet("reset");
        chk("reset ovf",   32'(overflow),  32'd0);
        chk("reset state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_quiet("post reset idle");

        launch(27'd12_345_678);
        observe("v12345678", 32'h1234_5678, 1'b0, 0, 1'b0, '0, 0);

        launch(27'd0);
        observe("v0", 32'h0000_0000, 1'b0, 0, 1'b0, '0, 0);

        launch(27'd99_999_999);
        observe("vmax", 32'h9999_9999, 1'b0, 0, 1'b0, '0, 0);

        launch(27'd100_000_000);
        observe("vovf", 32'h9999_9999, 1'b1, 0, 1'b0, '0, 0);
        repeat (3) @(negedge clock);
        chk("ovf hold", 32'(overflow), 32'd1);

        launch(27'd134_217_727);
        observe("vtop", 32'h9999_9999, 1'b1, 0, 1'b0, '0, 0);

        launch(27'd5);
        observe("v5 ignore", 32'h0000_0005, 1'b0, 10, 1'b0, '0, 0);

        launch(27'd10_203_040);
        observe("chain a", 32'h1020_3040, 1'b0, 0, 1'b1, 27'd87_654_321, 0);
        observe("chain b", 32'h8765_4321, 1'b0, 0, 1'b0, '0, 0);

        launch(27'd12_345_678);
        observe("abort", 32'h1234_5678, 1'b0, 0, 1'b0, '0, 30);

        launch(27'd42);
        observe("v42", 32'h0000_0042, 1'b0, 0, 1'b0, '0, 0);

        // report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
